vga_stream_gen: RTL and testbench

- Source of the 26-bit RGB pixel stream consumed by every text/graphics overlay stage (character drawers, sprite stages).
- Generates horizontal/vertical counters, sync pulses, active flag and a base background colour; packs them into the stream format.
- Sits directly upstream of the first overlay stage; its output feeds that stage's RGBStr_i unchanged.

---
 rtl/vga_stream_gen.sv | 85 ++++++++
 tb/tb_vga_stream_gen.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/vga_stream_gen.sv
// vga_stream_gen: VGA timing counters, syncs and background colour packed into the 26-bit overlay stream.
// Define VGA_STREAM_TESTBARS_EN to replace color_bg with eight vertical colour bars across the active area.
module vga_stream_gen #(
    parameter int unsigned HACT     = 640,
    parameter int unsigned HFP      = 16,
    parameter int unsigned HSYNC    = 96,
    parameter int unsigned HBP      = 48,
    parameter int unsigned VACT     = 480,
    parameter int unsigned VFP      = 10,
    parameter int unsigned VSYNC    = 2,
    parameter int unsigned VBP      = 33,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter logic [2:0]  color_bg = 3'b000
) (
    input  logic        px_clk,
    input  logic        reset_n,
    input  logic        px_en,
    output logic [25:0] RGBStr_o,
    output logic        frame_start
);

    localparam int unsigned CW     = 10;
    localparam int unsigned HTOTAL = HACT + HFP + HSYNC + HBP;
    localparam int unsigned VTOTAL = VACT + VFP + VSYNC + VBP;
    localparam int unsigned HS_BEG = HACT + HFP;
    localparam int unsigned HS_END = HS_BEG + HSYNC;
    localparam int unsigned VS_BEG = VACT + VFP;
    localparam int unsigned VS_END = VS_BEG + VSYNC;
    localparam logic [25:0] STR_RST = {3'b000, 20'd0, ~HS_POL, ~VS_POL, 1'b0};

    logic [CW-1:0] hc, vc, hc_nxt, vc_nxt;
    logic [25:0]   str_nxt;
    logic          fs_nxt;
    logic          active_c, hs_c, vs_c;
    logic [2:0]    rgb_c, pix_c;

`ifdef VGA_STREAM_TESTBARS_EN
    localparam int unsigned BAR_W = HACT / 8;
    logic [2:0] unused_bg;

    assign unused_bg = color_bg;
    // Bar index counts down from white (7) at the left edge to black (0) at the right.
    assign pix_c     = 3'(CW'(7) - hc / CW'(BAR_W));
`else
    assign pix_c     = color_bg;
`endif

    // Decode from the pre-edge counters, then advance; everything holds while px_en is low.
    always_comb begin
        hc_nxt   = hc;
        vc_nxt   = vc;
        str_nxt  = RGBStr_o;
        fs_nxt   = 1'b0;
        active_c = (hc < CW'(HACT)) && (vc < CW'(VACT));
        hs_c     = ((hc >= CW'(HS_BEG)) && (hc < CW'(HS_END))) ? HS_POL : ~HS_POL;
        vs_c     = ((vc >= CW'(VS_BEG)) && (vc < CW'(VS_END))) ? VS_POL : ~VS_POL;
        rgb_c    = active_c ? pix_c : 3'b000;
        if (px_en) begin
            str_nxt = {rgb_c, hc, vc, hs_c, vs_c, active_c};
            fs_nxt  = (hc == '0) && (vc == '0);
            if (hc == CW'(HTOTAL - 1)) begin
                hc_nxt = '0;
                vc_nxt = (vc == CW'(VTOTAL - 1)) ? '0 : vc + CW'(1);
            end else begin
                hc_nxt = hc + CW'(1);
            end
        end
    end

    always_ff @(posedge px_clk or negedge reset_n) begin
        if (!reset_n) begin
            hc          <= '0;
            vc          <= '0;
            RGBStr_o    <= STR_RST;
            frame_start <= 1'b0;
        end else begin
            hc          <= hc_nxt;
            vc          <= vc_nxt;
            RGBStr_o    <= str_nxt;
            frame_start <= fs_nxt;
        end
    end

endmodule

// File: tb/tb_vga_stream_gen.sv
// Directed bench for vga_stream_gen: a full-size instance for line timing and a shrunken one for frame timing.
module tb_vga_stream_gen;

    logic        px_clk = 1'b0;
    logic        reset_n;
    logic        px_en;
    logic [25:0] str_b, str_s;
    logic        fs_b, fs_s;

    vga_stream_gen #(.color_bg(3'b010)) u_big (
        .px_clk      (px_clk),
        .reset_n     (reset_n),
        .px_en       (px_en),
        .RGBStr_o    (str_b),
        .frame_start (fs_b)
    );

    // 24 x 13 frame, active-high syncs: HS for x 18..20, VS for y 8..9, 312 cycles per frame.
    vga_stream_gen #(
        .HACT(16), .HFP(2), .HSYNC(3), .HBP(3),
        .VACT(6),  .VFP(2), .VSYNC(2), .VBP(3),
        .HS_POL(1'b1), .VS_POL(1'b1), .color_bg(3'b101)
    ) u_small (
        .px_clk      (px_clk),
        .reset_n     (reset_n),
        .px_en       (px_en),
        .RGBStr_o    (str_s),
        .frame_start (fs_s)
    );

    always #5 px_clk = ~px_clk;

    typedef struct {
        int          n;
        bit          sel;
        logic [26:0] exp;
    } vec_t;

    vec_t tbl[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   fs_bad  = 0;
    int   fs_cnt  = 0;

    // {frame_start, B G R, XC, YC, HS, VS, Active}
    function automatic logic [26:0] w(logic fs, logic [2:0] rgb, int xc, int yc,
                                      logic hs, logic vs, logic a);
        return {fs, rgb, 10'(xc), 10'(yc), hs, vs, a};
    endfunction

    function automatic logic [2:0] rgb_b(int xc);
`ifdef VGA_STREAM_TESTBARS_EN
        return 3'(7 - xc / 80);
`else
        return 3'b010;
`endif
    endfunction

    function automatic logic [2:0] rgb_s(int xc);
`ifdef VGA_STREAM_TESTBARS_EN
        return 3'(7 - xc / 2);
`else
        return 3'b101;
`endif
    endfunction

    task automatic add(int n, bit sel, logic [26:0] e);
        vec_t v;
        v.n = n; v.sel = sel; v.exp = e;
        tbl.push_back(v);
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge px_clk);
        @(negedge px_clk);
    endtask

    initial begin
        reset_n = 1'b0;
        px_en   = 1'b1;

        // Full-size line: Active ends at 640, HS low 656..751, wrap at 799.
        add(0,   1'b0, w(1, rgb_b(0),   0,   0, 1, 1, 1));
        add(1,   1'b0, w(0, rgb_b(1),   1,   0, 1, 1, 1));
        add(80,  1'b0, w(0, rgb_b(80),  80,  0, 1, 1, 1));
        add(639, 1'b0, w(0, rgb_b(639), 639, 0, 1, 1, 1));
        add(640, 1'b0, w(0, 3'b000, 640, 0, 1, 1, 0));
        add(655, 1'b0, w(0, 3'b000, 655, 0, 1, 1, 0));
        add(656, 1'b0, w(0, 3'b000, 656, 0, 0, 1, 0));
        add(700, 1'b0, w(0, 3'b000, 700, 0, 0, 1, 0));
        add(751, 1'b0, w(0, 3'b000, 751, 0, 0, 1, 0));
        add(752, 1'b0, w(0, 3'b000, 752, 0, 1, 1, 0));
        add(799, 1'b0, w(0, 3'b000, 799, 0, 1, 1, 0));
        add(800, 1'b0, w(0, rgb_b(0), 0, 1, 1, 1, 1));
        add(801, 1'b0, w(0, rgb_b(1), 1, 1, 1, 1, 1));

        // Shrunken frame: vertical blanking, VS window and frame wrap.
        add(0,   1'b1, w(1, rgb_s(0),  0,  0,  0, 0, 1));
        add(15,  1'b1, w(0, rgb_s(15), 15, 0,  0, 0, 1));
        add(16,  1'b1, w(0, 3'b000, 16, 0,  0, 0, 0));
        add(17,  1'b1, w(0, 3'b000, 17, 0,  0, 0, 0));
        add(18,  1'b1, w(0, 3'b000, 18, 0,  1, 0, 0));
        add(20,  1'b1, w(0, 3'b000, 20, 0,  1, 0, 0));
        add(21,  1'b1, w(0, 3'b000, 21, 0,  0, 0, 0));
        add(23,  1'b1, w(0, 3'b000, 23, 0,  0, 0, 0));
        add(24,  1'b1, w(0, rgb_s(0), 0, 1, 0, 0, 1));
        add(143, 1'b1, w(0, 3'b000, 23, 5,  0, 0, 0));
        add(144, 1'b1, w(0, 3'b000, 0,  6,  0, 0, 0));
        add(191, 1'b1, w(0, 3'b000, 23, 7,  0, 0, 0));
        add(192, 1'b1, w(0, 3'b000, 0,  8,  0, 1, 0));
        add(239, 1'b1, w(0, 3'b000, 23, 9,  0, 1, 0));
        add(240, 1'b1, w(0, 3'b000, 0,  10, 0, 0, 0));
        add(311, 1'b1, w(0, 3'b000, 23, 12, 0, 0, 0));
        add(312, 1'b1, w(1, rgb_s(0), 0, 0, 0, 0, 1));
        add(313, 1'b1, w(0, rgb_s(1), 1, 0, 0, 0, 1));

        repeat (3) @(negedge px_clk);
        chk("reset big",   {5'd0, fs_b, str_b}, {5'd0, w(0, 3'b000, 0, 0, 1, 1, 0)});
        chk("reset small", {5'd0, fs_s, str_s}, {5'd0, w(0, 3'b000, 0, 0, 0, 0, 0)});
        reset_n = 1'b1;

        // Enabled edge k carries counter value k in its output.
        for (int k = 0; k <= 935; k++) begin
            step();
            foreach (tbl[i]) begin
                if (tbl[i].n == k)
                    chk($sformatf("%s n=%0d", tbl[i].sel ? "small" : "big", k),
                        tbl[i].sel ? {5'd0, fs_s, str_s} : {5'd0, fs_b, str_b},
                        {5'd0, tbl[i].exp});
            end
            if (fs_s !== (k % 312 == 0)) fs_bad++;
            if (fs_s === 1'b1) fs_cnt++;
        end
        chk("small frame_start misplaced", 32'(fs_bad), 32'd0);
        chk("small frame_start count", 32'(fs_cnt), 32'd3);

        // px_en 1,0,0,1 starting on a frame-start cycle of the small instance.
        step();
        chk("en1 small", {5'd0, fs_s, str_s}, {5'd0, w(1, rgb_s(0), 0, 0, 0, 0, 1)});
        chk("en1 big",   {5'd0, fs_b, str_b}, {5'd0, w(0, rgb_b(136), 136, 1, 1, 1, 1)});
        px_en = 1'b0;
        for (int j = 0; j < 2; j++) begin
            step();
            chk($sformatf("hold%0d small", j), {5'd0, fs_s, str_s}, {5'd0, w(0, rgb_s(0), 0, 0, 0, 0, 1)});
            chk($sformatf("hold%0d big", j),   {5'd0, fs_b, str_b}, {5'd0, w(0, rgb_b(136), 136, 1, 1, 1, 1)});
        end
        px_en = 1'b1;
        step();
        chk("en4 small", {5'd0, fs_s, str_s}, {5'd0, w(0, rgb_s(1), 1, 0, 0, 0, 1)});
        chk("en4 big",   {5'd0, fs_b, str_b}, {5'd0, w(0, rgb_b(137), 137, 1, 1, 1, 1)});

        // Asynchronous reset between clock edges, mid-line.
        #2 reset_n = 1'b0;
        #1;
        chk("async reset big",   {5'd0, fs_b, str_b}, {5'd0, w(0, 3'b000, 0, 0, 1, 1, 0)});
        chk("async reset small", {5'd0, fs_s, str_s}, {5'd0, w(0, 3'b000, 0, 0, 0, 0, 0)});
        @(negedge px_clk);
        chk("held reset big", {5'd0, fs_b, str_b}, {5'd0, w(0, 3'b000, 0, 0, 1, 1, 0)});
        reset_n = 1'b1;
        step();
        chk("restart big",   {5'd0, fs_b, str_b}, {5'd0, w(1, rgb_b(0), 0, 0, 1, 1, 1)});
        chk("restart small", {5'd0, fs_s, str_s}, {5'd0, w(1, rgb_s(0), 0, 0, 0, 0, 1)});
        step();
        chk("restart+1 big", {5'd0, fs_b, str_b}, {5'd0, w(0, rgb_b(1), 1, 0, 1, 1, 1)});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
